// File: rtl/ex_ctrl_seq.sv
// Execute-stage control sequencer: decodes MIPS words into registered EX controls and
// paces issue around multi-cycle multiplies and branch resolve/flush windows.
module ex_ctrl_seq #(
  parameter int MULT_CYCLES = 4,
  parameter int BR_BUBBLES  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [31:0] instruction,
  input  logic        zero_EX,
  output logic        instr_ready,
  output logic [3:0]  alu_op,
  output logic [4:0]  shamt_EX,
  output logic        enhilo_EX,
  output logic [1:0]  regsel_EX,
  output logic        regwrite_EX,
  output logic        rdrt_EX,
  output logic        memwrite_EX,
  output logic [1:0]  alu_src_EX,
  output logic        GPIO_OUT,
  output logic        GPIO_IN,
  output logic        pc_src_EX,
  output logic        stall_FETCH,
  output logic        mult_busy,
  output logic        illegal_op
);

  typedef enum logic [1:0] {RUN, MULT_WAIT, BR_RESOLVE, BR_FLUSH} state_t;

  typedef struct packed {
    logic [3:0] alu_op;
    logic [4:0] shamt;
    logic       enhilo;
    logic [1:0] regsel;
    logic       regwrite;
    logic       rdrt;
    logic       memwrite;
    logic [1:0] alu_src;
    logic       gpio_out;
    logic       gpio_in;
  } ctrl_t;

  localparam logic [3:0] MULT_LOAD  = 4'(MULT_CYCLES - 1);
  localparam logic [1:0] FLUSH_LOAD = 2'(BR_BUBBLES - 1);

  state_t     state, state_nxt;
  ctrl_t      ctrl, ctrl_nxt, dec;
  logic [3:0] mcnt, mcnt_nxt;
  logic [1:0] fcnt, fcnt_nxt;
  logic       br_ne, br_ne_nxt;
  logic       pc_src, pc_src_nxt;
  logic       busy;
  logic       illegal, illegal_nxt;
  logic       legal, is_mult, is_branch, is_hilo;
  logic       accept, taken;
  logic [5:0] opcode, funct;
  logic [4:0] shamt;

  assign opcode = instruction[31:26];
  assign funct  = instruction[5:0];
  assign shamt  = instruction[10:6];

  always_comb begin
    dec       = '0;
    legal     = 1'b1;
    is_mult   = 1'b0;
    is_branch = 1'b0;
    is_hilo   = 1'b0;
    case (opcode)
      6'b000000: begin
        dec.regwrite = 1'b1;
        case (funct)
          6'b100000, 6'b100001: dec.alu_op = 4'b0100;
          6'b100010, 6'b100011: dec.alu_op = 4'b0101;
          6'b011000, 6'b011001: begin
            dec.alu_op   = {3'b011, funct[0]};
            dec.enhilo   = 1'b1;
            dec.regwrite = 1'b0;
            is_mult      = 1'b1;
            is_hilo      = 1'b1;
          end
          6'b100100: dec.alu_op = 4'b0000;
          6'b100101: dec.alu_op = 4'b0001;
          6'b100110: dec.alu_op = 4'b0011;
          6'b100111: dec.alu_op = 4'b0010;
          6'b000000: begin
            dec.alu_op = 4'b1000;
            dec.shamt  = shamt;
          end
          // Zero-distance right shifts are repurposed as GPIO write/read.
          6'b000010: begin
            dec.alu_op   = 4'b1001;
            dec.shamt    = shamt;
            dec.gpio_out = (shamt == 5'd0);
          end
          6'b000011: begin
            dec.alu_op  = 4'b1010;
            dec.shamt   = shamt;
            dec.gpio_in = (shamt == 5'd0);
          end
          6'b010000: begin
            dec.alu_op = 4'b1000;
            dec.regsel = 2'd1;
            is_hilo    = 1'b1;
          end
          6'b010010: begin
            dec.alu_op = 4'b1000;
            dec.regsel = 2'd2;
            is_hilo    = 1'b1;
          end
          6'b101010: dec.alu_op = 4'b1100;
          6'b101011: dec.alu_op = 4'b1101;
          default: begin
            dec   = '0;
            legal = 1'b0;
          end
        endcase
      end
      6'b001000, 6'b001001, 6'b001010: begin
        dec.alu_op   = (opcode == 6'b001010) ? 4'b1100 : 4'b0100;
        dec.alu_src  = 2'd1;
        dec.rdrt     = 1'b1;
        dec.regwrite = 1'b1;
      end
      6'b001100, 6'b001101, 6'b001110: begin
        dec.alu_op   = (opcode == 6'b001100) ? 4'b0000 :
                       (opcode == 6'b001101) ? 4'b0001 : 4'b0011;
        dec.alu_src  = 2'd2;
        dec.rdrt     = 1'b1;
        dec.regwrite = 1'b1;
      end
      6'b001111: begin
        dec.alu_op   = 4'b1000;
        dec.alu_src  = 2'd2;
        dec.shamt    = 5'd16;
        dec.memwrite = 1'b1;
        dec.rdrt     = 1'b1;
        dec.regwrite = 1'b1;
      end
      6'b000100, 6'b000101: begin
        dec.alu_op = 4'b0101;
        is_branch  = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

  // HI/LO consumers and new multiplies wait out the multiplier latency.
  assign instr_ready = ((state == RUN) || (state == MULT_WAIT)) &&
                       !(instr_valid && is_hilo && (mcnt != 4'd0));
  assign stall_FETCH = ~instr_ready;
  assign accept      = instr_valid & instr_ready;
  assign taken       = br_ne ? ~zero_EX : zero_EX;

  always_comb begin
    state_nxt   = state;
    ctrl_nxt    = '0;
    mcnt_nxt    = (mcnt != 4'd0) ? mcnt - 4'd1 : 4'd0;
    fcnt_nxt    = fcnt;
    br_ne_nxt   = br_ne;
    pc_src_nxt  = 1'b0;
    illegal_nxt = illegal;
    case (state)
      RUN, MULT_WAIT: begin
        if (state == MULT_WAIT && mcnt_nxt == 4'd0) state_nxt = RUN;
        if (accept) begin
          if (!legal)                    illegal_nxt = 1'b1;
          else if (instruction != 32'd0) ctrl_nxt    = dec;
          if (is_mult) begin
            mcnt_nxt  = MULT_LOAD;
            state_nxt = MULT_WAIT;
          end
          if (is_branch) begin
            state_nxt = BR_RESOLVE;
            br_ne_nxt = opcode[0];
          end
        end
      end
      BR_RESOLVE: begin
        if (taken) begin
          pc_src_nxt = 1'b1;
          fcnt_nxt   = FLUSH_LOAD;
          state_nxt  = BR_FLUSH;
        end else begin
          state_nxt = (mcnt_nxt != 4'd0) ? MULT_WAIT : RUN;
        end
      end
      BR_FLUSH: begin
        if (fcnt == 2'd0) state_nxt = (mcnt_nxt != 4'd0) ? MULT_WAIT : RUN;
        else              fcnt_nxt  = fcnt - 2'd1;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      ctrl    <= '0;
      mcnt    <= '0;
      fcnt    <= '0;
      br_ne   <= 1'b0;
      pc_src  <= 1'b0;
      busy    <= 1'b0;
      illegal <= 1'b0;
    end else begin
      state   <= state_nxt;
      ctrl    <= ctrl_nxt;
      mcnt    <= mcnt_nxt;
      fcnt    <= fcnt_nxt;
      br_ne   <= br_ne_nxt;
      pc_src  <= pc_src_nxt;
      busy    <= (mcnt_nxt != 4'd0);
      illegal <= illegal_nxt;
    end
  end

  assign alu_op      = ctrl.alu_op;
  assign shamt_EX    = ctrl.shamt;
  assign enhilo_EX   = ctrl.enhilo;
  assign regsel_EX   = ctrl.regsel;
  assign regwrite_EX = ctrl.regwrite;
  assign rdrt_EX     = ctrl.rdrt;
  assign memwrite_EX = ctrl.memwrite;
  assign alu_src_EX  = ctrl.alu_src;
  assign GPIO_OUT    = ctrl.gpio_out;
  assign GPIO_IN     = ctrl.gpio_in;
  assign pc_src_EX   = pc_src;
  assign mult_busy   = busy;
  assign illegal_op  = illegal;

endmodule

// File: tb/tb_ex_ctrl_seq.sv
// Bench for ex_ctrl_seq: expected EX controls are queued at issue and compared a cycle later.
module tb_ex_ctrl_seq;

  logic        clk = 1'b0;
  logic        rst, instr_valid, zero_EX;
  logic [31:0] instruction;
  logic        instr_ready, enhilo_EX, regwrite_EX, rdrt_EX, memwrite_EX;
  logic        GPIO_OUT, GPIO_IN, pc_src_EX, stall_FETCH, mult_busy, illegal_op;
  logic [3:0]  alu_op;
  logic [4:0]  shamt_EX;
  logic [1:0]  regsel_EX, alu_src_EX;

  int checks = 0;
  int errors = 0;
  logic [18:0] exp_q[$];
  logic        ill_exp;
  logic [18:0] obs;

  localparam logic [31:0] ADD   = 32'h00221820, SUB  = 32'h00221822, MULT = 32'h00220018;
  localparam logic [31:0] MFLO  = 32'h00002012, MFHI = 32'h00002810, BEQ  = 32'h10220004;
  localparam logic [31:0] BNE   = 32'h14220004, SRL0 = 32'h00021802, SRA0 = 32'h00021803;
  localparam logic [31:0] SRL4  = 32'h00021902, ADDI = 32'h20220005, ORI  = 32'h34220005;
  localparam logic [31:0] LUI   = 32'h3C021234, SLTI = 32'h28220005, NOR  = 32'h00221827;
  localparam logic [31:0] SLTU  = 32'h0022182B, ANDI = 32'h30220005, SLL3 = 32'h000218C0;
  localparam logic [31:0] OR    = 32'h00221825, ILL  = 32'hFC000000, BADF = 32'h0022183F;

  always #5 clk = ~clk;

  assign obs = {alu_op, shamt_EX, enhilo_EX, regsel_EX, regwrite_EX, rdrt_EX, memwrite_EX,
                alu_src_EX, GPIO_OUT, GPIO_IN};

  ex_ctrl_seq #(.MULT_CYCLES(4), .BR_BUBBLES(2)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instruction(instruction),
    .zero_EX(zero_EX), .instr_ready(instr_ready), .alu_op(alu_op), .shamt_EX(shamt_EX),
    .enhilo_EX(enhilo_EX), .regsel_EX(regsel_EX), .regwrite_EX(regwrite_EX),
    .rdrt_EX(rdrt_EX), .memwrite_EX(memwrite_EX), .alu_src_EX(alu_src_EX),
    .GPIO_OUT(GPIO_OUT), .GPIO_IN(GPIO_IN), .pc_src_EX(pc_src_EX),
    .stall_FETCH(stall_FETCH), .mult_busy(mult_busy), .illegal_op(illegal_op)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", tag, $time, act, exp);
    end
  endtask

  // Returns {illegal, alu_op, shamt, enhilo, regsel, regwrite, rdrt, memwrite, alu_src, gpio_out, gpio_in}.
  function automatic logic [19:0] model(input logic [31:0] w);
    logic [3:0] op;
    logic [4:0] sh;
    logic [1:0] rs, src;
    logic       hl, rw, rt, mw, go, gi, bad;
    op = 4'h0; sh = 5'd0; rs = 2'd0; src = 2'd0;
    hl = 1'b0; rw = 1'b0; rt = 1'b0; mw = 1'b0; go = 1'b0; gi = 1'b0; bad = 1'b0;
    if (w == 32'd0) begin
      bad = 1'b0;
    end else if (w[31:26] == 6'd0) begin
      rw = 1'b1;
      case (w[5:0])
        6'h20, 6'h21: op = 4'h4;
        6'h22, 6'h23: op = 4'h5;
        6'h18: begin op = 4'h6; hl = 1'b1; rw = 1'b0; end
        6'h19: begin op = 4'h7; hl = 1'b1; rw = 1'b0; end
        6'h24: op = 4'h0;
        6'h25: op = 4'h1;
        6'h26: op = 4'h3;
        6'h27: op = 4'h2;
        6'h00: begin op = 4'h8; sh = w[10:6]; end
        6'h02: begin op = 4'h9; sh = w[10:6]; go = (w[10:6] == 5'd0); end
        6'h03: begin op = 4'hA; sh = w[10:6]; gi = (w[10:6] == 5'd0); end
        6'h10: begin op = 4'h8; rs = 2'd1; end
        6'h12: begin op = 4'h8; rs = 2'd2; end
        6'h2A: op = 4'hC;
        6'h2B: op = 4'hD;
        default: begin rw = 1'b0; bad = 1'b1; end
      endcase
    end else begin
      case (w[31:26])
        6'h08, 6'h09: begin op = 4'h4; src = 2'd1; rt = 1'b1; rw = 1'b1; end
        6'h0A: begin op = 4'hC; src = 2'd1; rt = 1'b1; rw = 1'b1; end
        6'h0C: begin op = 4'h0; src = 2'd2; rt = 1'b1; rw = 1'b1; end
        6'h0D: begin op = 4'h1; src = 2'd2; rt = 1'b1; rw = 1'b1; end
        6'h0E: begin op = 4'h3; src = 2'd2; rt = 1'b1; rw = 1'b1; end
        6'h0F: begin op = 4'h8; src = 2'd2; sh = 5'd16; mw = 1'b1; rt = 1'b1; rw = 1'b1; end
        6'h04, 6'h05: op = 4'h5;
        default: bad = 1'b1;
      endcase
    end
    return {bad, op, sh, hl, rs, rw, rt, mw, src, go, gi};
  endfunction

  // One clock: drive, check this cycle's outputs, queue what the next cycle must show.
  task automatic cyc(input logic r, input logic v, input logic [31:0] w, input logic z,
                     input logic er, input logic eb, input logic ep);
    logic [19:0] m;
    rst = r; instr_valid = v; instruction = w; zero_EX = z;
    @(negedge clk);
    check("instr_ready", instr_ready, er);
    check("stall_FETCH", stall_FETCH, !er);
    check("mult_busy", mult_busy, eb);
    check("pc_src_EX", pc_src_EX, ep);
    check("illegal_op", illegal_op, ill_exp);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard underflow at %0t", $time);
    end else begin
      check("ctrl", obs, exp_q.pop_front());
    end
    m = model(w);
    if (r) begin
      exp_q.push_back('0);
      ill_exp = 1'b0;
    end else if (v && er) begin
      exp_q.push_back(m[18:0]);
      if (m[19]) ill_exp = 1'b1;
    end else begin
      exp_q.push_back('0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; instr_valid = 1'b0; instruction = '0; zero_EX = 1'b0; ill_exp = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back('0);
    //  rst  v     word  z     rdy   busy  pc
    cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, ADD,  1'b0, 1'b1, 1'b0, 1'b0);
    // mult then back-to-back mflo held off until the counter drains
    cyc(1'b0, 1'b1, MULT, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, MFLO, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, MFLO, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, MFLO, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, MFLO, 1'b0, 1'b1, 1'b0, 1'b0);
    // non-HI/LO work and a taken beq issue while the multiplier runs
    cyc(1'b0, 1'b1, MULT, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, ADD,  1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, BEQ,  1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, SUB,  1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, SUB,  1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, SUB,  1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, OR,   1'b0, 1'b1, 1'b0, 1'b0);
    // bne not taken: a single stall cycle
    cyc(1'b0, 1'b1, BNE,  1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, ADD,  1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, ADD,  1'b0, 1'b1, 1'b0, 1'b0);
    // not-taken beq during a multiply returns to MULT_WAIT
    cyc(1'b0, 1'b1, MULT, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, BEQ,  1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, MFLO, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, MFLO, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, MFLO, 1'b0, 1'b1, 1'b0, 1'b0);
    begin
      logic [31:0] words[13];
      words = '{SRL0, SRA0, SRL4, ADDI, ORI, LUI, SLTI, NOR, MFHI, 32'd0, SLTU, ANDI, SLL3};
      foreach (words[i]) cyc(1'b0, 1'b1, words[i], 1'b0, 1'b1, 1'b0, 1'b0);
    end
    // illegal encodings are bubbles and latch illegal_op
    cyc(1'b0, 1'b1, ILL,  1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, BADF, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, ADD,  1'b0, 1'b1, 1'b0, 1'b0);
    // reset in the middle of a multiply
    cyc(1'b0, 1'b1, MULT, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, ADD,  1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
